// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch lookup, EX resolution and perf signals of the branch predictor
interface branch_predictor_if;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [2:0]  ex_branch_type;
  logic        ex_is_call;
  logic        ex_is_ret;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;
  modport master (
    output if_valid, if_pc, ex_valid, ex_pc, ex_branch_type, ex_is_call, ex_is_ret,
           ex_taken, ex_target, ex_pred_taken, ex_pred_target,
    input  pred_taken, pred_target, mispredict, redirect_pc, perf_branches, perf_mispredicts
  );
  modport slave (
    input  if_valid, if_pc, ex_valid, ex_pc, ex_branch_type, ex_is_call, ex_is_ret,
           ex_taken, ex_target, ex_pred_taken, ex_pred_target,
    output pred_taken, pred_target, mispredict, redirect_pc, perf_branches, perf_mispredicts
  );
endinterface

// File: rtl/branch_predictor.sv
// branch_predictor: 2-bit BHT, tagged BTB and circular RAS with same-cycle fetch prediction
module branch_predictor #(
  parameter int BHT_ENTRIES = 64,
  parameter int BTB_ENTRIES = 16,
  parameter int RAS_DEPTH   = 8
) (
  input logic clk,
  input logic rst,
  branch_predictor_if.slave bp
);
  localparam int BI = $clog2(BHT_ENTRIES);
  localparam int TI = $clog2(BTB_ENTRIES);
  localparam int RI = $clog2(RAS_DEPTH);
  localparam int TW = 30 - TI;
  localparam logic [2:0] B_EQNE = 3'd1;
  localparam logic [2:0] B_LTGE = 3'd2;
  localparam logic [2:0] B_JUMP = 3'd3;
  localparam logic [2:0] B_JREG = 3'd4;
  localparam logic [1:0] K_COND = 2'd0;
  localparam logic [1:0] K_JUMP = 2'd1;
  localparam logic [1:0] K_JREG = 2'd2;
  localparam logic [1:0] K_RET  = 2'd3;
  localparam logic [RI:0] FULL  = (RI + 1)'(RAS_DEPTH);
  logic [1:0]    bht        [BHT_ENTRIES];
  logic          btb_valid  [BTB_ENTRIES];
  logic [TW-1:0] btb_tag    [BTB_ENTRIES];
  logic [31:0]   btb_target [BTB_ENTRIES];
  logic [1:0]    btb_kind   [BTB_ENTRIES];
  logic [31:0]   ras        [RAS_DEPTH];
  logic [RI-1:0] ras_ptr;
  logic [RI:0]   ras_count;
  logic [BI-1:0] if_bi, ex_bi;
  logic [TI-1:0] if_ti, ex_ti;
  logic [1:0]    if_kind, ex_kind;
  logic          hit, ex_cond, do_pop;
  logic [RI-1:0] pop_ptr;
  logic [RI:0]   pop_count;
  assign if_bi   = bp.if_pc[BI+1:2];
  assign if_ti   = bp.if_pc[TI+1:2];
  assign ex_bi   = bp.ex_pc[BI+1:2];
  assign ex_ti   = bp.ex_pc[TI+1:2];
  assign if_kind = btb_kind[if_ti];
  assign ex_cond = bp.ex_branch_type == B_EQNE || bp.ex_branch_type == B_LTGE;
  assign ex_kind = bp.ex_is_ret ? K_RET : bp.ex_branch_type == B_JUMP ? K_JUMP :
                   bp.ex_branch_type == B_JREG ? K_JREG : K_COND;
  assign do_pop    = bp.ex_is_ret && ras_count != '0;
  assign pop_ptr   = do_pop ? ras_ptr - RI'(1) : ras_ptr;
  assign pop_count = do_pop ? ras_count - (RI + 1)'(1) : ras_count;
  // Fetch-side lookup against pre-update table state
  always_comb begin
    hit            = bp.if_valid && btb_valid[if_ti] && btb_tag[if_ti] == bp.if_pc[31:TI+2];
    bp.pred_taken  = hit && (if_kind != K_COND || bht[if_bi][1]);
    bp.pred_target = !bp.pred_taken ? bp.if_pc + 32'd4 :
                     (if_kind == K_RET && ras_count != '0) ? ras[ras_ptr - RI'(1)] :
                     btb_target[if_ti];
  end
  // Resolution-side redirect decision
  always_comb begin
    bp.mispredict  = bp.ex_valid && (bp.ex_pred_taken != bp.ex_taken ||
                     (bp.ex_taken && bp.ex_pred_target != bp.ex_target));
    bp.redirect_pc = bp.ex_taken ? bp.ex_target : bp.ex_pc + 32'd8;
  end
  // Saturating 2-bit direction counters, trained by conditional branches only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
    end else if (bp.ex_valid && ex_cond) begin
      bht[ex_bi] <= bp.ex_taken ? (bht[ex_bi] == 2'b11 ? 2'b11 : bht[ex_bi] + 2'd1) :
                                  (bht[ex_bi] == 2'b00 ? 2'b00 : bht[ex_bi] - 2'd1);
    end
  end
  // Taken transfers allocate or replace the BTB entry at their index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
        btb_kind[i]   <= K_COND;
      end
    end else if (bp.ex_valid && bp.ex_taken) begin
      btb_valid[ex_ti]  <= 1'b1;
      btb_tag[ex_ti]    <= bp.ex_pc[31:TI+2];
      btb_target[ex_ti] <= bp.ex_target;
      btb_kind[ex_ti]   <= ex_kind;
    end
  end
  // Return stack: pop first, then push; a full push overwrites the oldest entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RAS_DEPTH; i++) ras[i] <= '0;
      ras_ptr   <= '0;
      ras_count <= '0;
    end else if (bp.ex_valid && bp.ex_is_call) begin
      ras[pop_ptr] <= bp.ex_pc + 32'd8;
      ras_ptr      <= pop_ptr + RI'(1);
      ras_count    <= pop_count == FULL ? pop_count : pop_count + (RI + 1)'(1);
    end else if (bp.ex_valid) begin
      ras_ptr   <= pop_ptr;
      ras_count <= pop_count;
    end
  end
  // Event counters, free-running wrap at 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bp.perf_branches    <= '0;
      bp.perf_mispredicts <= '0;
    end else if (bp.ex_valid) begin
      bp.perf_branches    <= bp.perf_branches + 32'd1;
      bp.perf_mispredicts <= bp.perf_mispredicts + {31'd0, bp.mispredict};
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed, table-driven and randomized checks against a queue-based model
module tb_branch_predictor;
  localparam logic [2:0] B_EQNE = 3'd1;
  localparam logic [2:0] B_LTGE = 3'd2;
  localparam logic [2:0] B_JUMP = 3'd3;
  localparam logic [2:0] B_JREG = 3'd4;
  typedef struct {
    logic v; logic [31:0] pc; logic [2:0] ty; logic call, ret, tk;
    logic [31:0] tgt; logic ptk; logic [31:0] ptgt;
  } ex_t;
  typedef struct {
    logic v; logic [31:0] pc; logic tk; logic [31:0] tgt; logic ptk; logic [31:0] ptgt;
    logic em; logic [31:0] er;
  } vec_t;
  logic clk = 0, rst = 1;
  int pass = 0, total = 0;
  int m_bht [64];
  bit m_v [16];
  logic [31:0] m_pc [16], m_tgt [16];
  int m_kind [16];
  logic [31:0] m_q [$];
  int m_br, m_mis;
  logic s_tk, s_mis;
  logic [31:0] s_tgt, s_red;
  ex_t idle;
  branch_predictor_if bus ();
  branch_predictor dut (.clk(clk), .rst(rst), .bp(bus));
  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got === exp) pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic m_reset();
    for (int i = 0; i < 64; i++) m_bht[i] = 1;
    for (int i = 0; i < 16; i++) m_v[i] = 0;
    m_q.delete();
    m_br = 0;
    m_mis = 0;
  endtask

  function automatic logic [32:0] m_predict(logic iv, logic [31:0] pc);
    int ti = int'((pc >> 2) % 16);
    int bi = int'((pc >> 2) % 64);
    logic tk;
    if (!iv || !m_v[ti] || (m_pc[ti] >> 6) != (pc >> 6)) return {1'b0, pc + 32'd4};
    tk = m_kind[ti] != 0 || m_bht[bi] >= 2;
    if (!tk) return {1'b0, pc + 32'd4};
    if (m_kind[ti] == 3 && m_q.size() > 0) return {1'b1, m_q[$]};
    return {1'b1, m_tgt[ti]};
  endfunction

  function automatic logic m_mispredict(ex_t e);
    return e.v && (e.ptk != e.tk || (e.tk && e.ptgt != e.tgt));
  endfunction

  task automatic m_update(ex_t e);
    int ti = int'((e.pc >> 2) % 16);
    int bi = int'((e.pc >> 2) % 64);
    if (!e.v) return;
    m_br++;
    if (m_mispredict(e)) m_mis++;
    if (e.ty == B_EQNE || e.ty == B_LTGE)
      m_bht[bi] = e.tk ? (m_bht[bi] < 3 ? m_bht[bi] + 1 : 3) : (m_bht[bi] > 0 ? m_bht[bi] - 1 : 0);
    if (e.tk) begin
      m_v[ti] = 1;
      m_pc[ti] = e.pc;
      m_tgt[ti] = e.tgt;
      m_kind[ti] = e.ret ? 3 : e.ty == B_JUMP ? 1 : e.ty == B_JREG ? 2 : 0;
    end
    if (e.ret && m_q.size() > 0) void'(m_q.pop_back());
    if (e.call) begin
      m_q.push_back(e.pc + 32'd8);
      if (m_q.size() > 8) void'(m_q.pop_front());
    end
  endtask

  task automatic do_cycle(logic iv, logic [31:0] ipc, ex_t e);
    logic [32:0] p;
    bus.if_valid = iv; bus.if_pc = ipc;
    bus.ex_valid = e.v; bus.ex_pc = e.pc; bus.ex_branch_type = e.ty;
    bus.ex_is_call = e.call; bus.ex_is_ret = e.ret; bus.ex_taken = e.tk;
    bus.ex_target = e.tgt; bus.ex_pred_taken = e.ptk; bus.ex_pred_target = e.ptgt;
    #2;
    s_tk = bus.pred_taken; s_tgt = bus.pred_target; s_mis = bus.mispredict; s_red = bus.redirect_pc;
    p = m_predict(iv, ipc);
    chk("pred_taken", {31'd0, s_tk}, {31'd0, p[32]});
    chk("pred_target", s_tgt, p[31:0]);
    chk("mispredict", {31'd0, s_mis}, {31'd0, m_mispredict(e)});
    chk("redirect_pc", s_red, e.tk ? e.tgt : e.pc + 32'd8);
    chk("perf_branches", bus.perf_branches, m_br);
    chk("perf_mispredicts", bus.perf_mispredicts, m_mis);
    @(posedge clk);
    m_update(e);
    @(negedge clk);
  endtask

  task automatic look(logic [31:0] pc, logic etk, logic [31:0] etgt, string name);
    do_cycle(1'b1, pc, idle);
    chk({name, "_taken"}, {31'd0, s_tk}, {31'd0, etk});
    chk({name, "_target"}, s_tgt, etgt);
  endtask

  task automatic do_reset();
    rst = 1;
    m_reset();
    @(negedge clk);
    rst = 0;
  endtask

  function automatic ex_t mk(logic [31:0] pc, logic [2:0] ty, logic call, logic ret, logic tk, logic [31:0] tgt);
    ex_t e;
    e.v = 1; e.pc = pc; e.ty = ty; e.call = call; e.ret = ret; e.tk = tk; e.tgt = tgt;
    e.ptk = 0; e.ptgt = 32'h0;
    return e;
  endfunction

  function automatic logic [31:0] rpc();
    logic [31:0] b = 32'h00400000 + 32'($urandom_range(0, 23)) * 4;
    return ($urandom_range(0, 3) == 0) ? b + 32'h40 * 32'($urandom_range(1, 3)) : b;
  endfunction

  localparam logic [31:0] P = 32'h00400020, T = 32'h00400100, R = 32'h00400804;
  vec_t vt [6];
  ex_t e;
  logic [32:0] p;
  int exp_br, exp_mis;

  initial begin
    idle = '{v: 0, pc: 0, ty: 0, call: 0, ret: 0, tk: 0, tgt: 0, ptk: 0, ptgt: 0};
    bus.if_valid = 0; bus.if_pc = 0; bus.ex_valid = 0; bus.ex_pc = 0; bus.ex_branch_type = 0;
    bus.ex_is_call = 0; bus.ex_is_ret = 0; bus.ex_taken = 0; bus.ex_target = 0;
    bus.ex_pred_taken = 0; bus.ex_pred_target = 0;
    @(negedge clk);
    do_reset();
    chk("idle_pred_taken", {31'd0, bus.pred_taken}, 32'd0);
    chk("idle_mispredict", {31'd0, bus.mispredict}, 32'd0);
    look(32'h00400010, 0, 32'h00400014, "reset_lookup");
    // same-cycle write/read sees old state, then counter training and saturation
    do_cycle(1, P, mk(P, B_EQNE, 0, 0, 1, T));
    chk("same_cycle_old_taken", {31'd0, s_tk}, 32'd0);
    chk("same_cycle_old_target", s_tgt, P + 4);
    do_cycle(1, P, mk(P, B_EQNE, 0, 0, 1, T));
    chk("next_cycle_new_taken", {31'd0, s_tk}, 32'd1);
    chk("next_cycle_new_target", s_tgt, T);
    look(P, 1, T, "ctr11");
    do_cycle(0, 0, mk(P, B_EQNE, 0, 0, 1, T));
    do_cycle(0, 0, mk(P, B_EQNE, 0, 0, 0, 0));
    look(P, 1, T, "sat_top");
    for (int i = 0; i < 3; i++) do_cycle(0, 0, mk(P, B_LTGE, 0, 0, 0, 0));
    look(P, 0, P + 4, "ctr00");
    do_cycle(0, 0, mk(P, B_EQNE, 0, 0, 1, T));
    look(P, 0, P + 4, "sat_bottom");
    // return stack
    do_reset();
    do_cycle(0, 0, mk(R, B_JREG, 0, 1, 1, 32'h00400abc));
    do_cycle(0, 0, mk(32'h00400040, B_JUMP, 1, 0, 1, 32'h00400800));
    look(R, 1, 32'h00400048, "ras_single");
    do_cycle(0, 0, mk(R, B_JREG, 0, 1, 1, 32'h00400048));
    for (int k = 0; k < 9; k++) do_cycle(0, 0, mk(32'h00401000 + 32'h40 * k, B_JUMP, 1, 0, 1, 32'h00400800));
    for (int k = 0; k < 9; k++) begin
      look(R, 1, k < 8 ? 32'h00401008 + 32'h40 * (8 - k) : 32'h0050001c, "ras_pop");
      do_cycle(0, 0, mk(R, B_JREG, 0, 1, 1, 32'h00500000 + 4 * k));
    end
    // BTB aliasing
    do_reset();
    do_cycle(0, 0, mk(32'h00400000, B_JUMP, 0, 0, 1, 32'h00400200));
    do_cycle(0, 0, mk(32'h00400040, B_JUMP, 0, 0, 1, 32'h00400300));
    look(32'h00400000, 0, 32'h00400004, "alias_miss");
    look(32'h00400040, 1, 32'h00400300, "alias_hit");
    // mispredict / redirect table
    vt[0] = '{v: 1, pc: 32'h00500000, tk: 1, tgt: 32'h2000, ptk: 1, ptgt: 32'h1000, em: 1, er: 32'h2000};
    vt[1] = '{v: 1, pc: 32'h3000, tk: 0, tgt: 32'h0, ptk: 1, ptgt: 32'h3100, em: 1, er: 32'h3008};
    vt[2] = '{v: 1, pc: 32'h3000, tk: 0, tgt: 32'h0, ptk: 0, ptgt: 32'h1234, em: 0, er: 32'h3008};
    vt[3] = '{v: 1, pc: 32'h4000, tk: 1, tgt: 32'h4400, ptk: 1, ptgt: 32'h4400, em: 0, er: 32'h4400};
    vt[4] = '{v: 1, pc: 32'h4000, tk: 1, tgt: 32'h4400, ptk: 0, ptgt: 32'h4400, em: 1, er: 32'h4400};
    vt[5] = '{v: 0, pc: 32'h5000, tk: 1, tgt: 32'h6000, ptk: 0, ptgt: 32'h0, em: 0, er: 32'h6000};
    do_reset();
    exp_br = 0;
    exp_mis = 0;
    for (int i = 0; i < 6; i++) begin
      e = mk(vt[i].pc, B_EQNE, 0, 0, vt[i].tk, vt[i].tgt);
      e.v = vt[i].v; e.ptk = vt[i].ptk; e.ptgt = vt[i].ptgt;
      do_cycle(0, 0, e);
      chk("vec_mispredict", {31'd0, s_mis}, {31'd0, vt[i].em});
      chk("vec_redirect", s_red, vt[i].er);
      exp_br += vt[i].v;
      exp_mis += vt[i].v & vt[i].em;
    end
    chk("vec_perf_branches", bus.perf_branches, exp_br);
    chk("vec_perf_mispredicts", bus.perf_mispredicts, exp_mis);
    // asynchronous reset while EX is training
    bus.if_valid = 1; bus.if_pc = 32'h4000; bus.ex_valid = 1; bus.ex_pc = 32'h4000;
    bus.ex_branch_type = B_JUMP; bus.ex_is_call = 1; bus.ex_taken = 1; bus.ex_target = 32'h4400;
    #2 rst = 1;
    #1;
    chk("async_perf_branches", bus.perf_branches, 0);
    chk("async_perf_mispredicts", bus.perf_mispredicts, 0);
    chk("async_pred_taken", {31'd0, bus.pred_taken}, 0);
    chk("async_pred_target", bus.pred_target, 32'h4004);
    @(posedge clk);
    @(negedge clk);
    m_reset();
    bus.ex_valid = 0;
    rst = 0;
    look(32'h4000, 0, 32'h4004, "post_reset");
    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      e.v = $urandom_range(0, 9) < 7;
      e.pc = rpc();
      e.ty = 3'($urandom_range(1, 4));
      e.ret = e.ty == B_JREG && $urandom_range(0, 1) == 1;
      e.call = $urandom_range(0, 3) == 0;
      e.tk = e.ty >= B_JUMP ? 1'b1 : 1'($urandom_range(0, 1));
      e.tgt = $urandom_range(0, 1) == 1 ? rpc() : ($urandom & ~32'h3);
      p = m_predict(1, e.pc);
      e.ptk = $urandom_range(0, 2) > 0 ? p[32] : 1'($urandom_range(0, 1));
      e.ptgt = $urandom_range(0, 2) > 0 ? p[31:0] : rpc();
      do_cycle($urandom_range(0, 4) > 0, rpc(), e);
    end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
